dm_port_arbiter: RTL
====================

// Module: dm_port_arbiter
// PURPOSE
//  Shares the single Debug Module slave port between two requesters:
//  - D: core data accesses decoded to 0xCD00_0000-0xCDFF_FFFF (read/write).
//  - I: debug-ROM instruction fetches (read-only).
//  Sits between aquila_top and dm_top. Replaces the combinational
//  priority mux with a sequenced, registered, fair transaction scheduler.
// PARAMETERS
//  XLEN        32  bus data/address width
//  RD_LATENCY  1   slave cycles from slave_req_o to valid slave_rdata_i (1..4)
//  PRIO_IFETCH 0   0 = round-robin on conflict; 1 = I always wins on conflict
// PORTS
//  clk_i          in   1      system clock
//  rst_i          in   1      synchronous, active-high reset
//  d_req_i        in   1      D request; held high until d_ready_o seen
//  d_we_i         in   1      D write enable (1 = write)
//  d_addr_i       in   XLEN   D byte address
//  d_be_i         in   XLEN/8 D byte enables
//  d_wdata_i      in   XLEN   D write data
//  d_ready_o      out  1      1-cycle completion pulse to D
//  d_rdata_o      out  XLEN   D read data, valid while d_ready_o
//  i_req_i        in   1      I fetch request; held high until i_ready_o seen
//  i_addr_i       in   XLEN   I fetch address
//  i_ready_o      out  1      1-cycle completion pulse to I
//  i_rdata_o      out  XLEN   I fetched word, valid while i_ready_o
//  slave_req_o    out  1      1-cycle request to DM slave
//  slave_we_o     out  1      DM write enable
//  slave_addr_o   out  XLEN   DM address
//  slave_be_o     out  XLEN/8 DM byte enables
//  slave_wdata_o  out  XLEN   DM write data
//  slave_rdata_i  in   XLEN   DM read data, RD_LATENCY cycles after slave_req_o
//  busy_o         out  1      1 whenever state != IDLE
// BEHAVIOUR
//  - One clock, clk_i. Reset is synchronous, active-high (rst_i): state=IDLE,
//    all outputs 0, wait counter 0, last_grant=D (first conflict goes to I).
//  - All outputs driven from flops; no combinational input->output path.
//  - FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//    IDLE : if any req, pick owner, latch owner's we/addr/be/wdata -> ISSUE.
//           No req -> stay IDLE.
//    ISSUE: slave_req_o=1 for exactly this cycle with latched fields; load
//           counter = RD_LATENCY-1 -> WAIT.
//    WAIT : counter decrements each cycle; at counter==0 capture slave_rdata_i
//           into owner's rdata register -> DONE. Lasts RD_LATENCY cycles.
//    DONE : owner's ready_o=1 for this cycle only; update last_grant -> IDLE.
//  - Latency: req sampled in cycle 0 -> slave_req_o cycle 1 -> ready_o cycle
//    RD_LATENCY+2. Back-to-back issue period = RD_LATENCY+3 cycles.
//  - Writes follow the same sequence; rdata captured but don't-care.
//  - I port: slave_we_o=0, slave_be_o=all ones, slave_wdata_o=0.
//  - Non-owner outputs: slave_* fields 0 outside ISSUE; non-owner ready_o=0.
//  - rdata_o registers hold last captured value until next own capture.
//  - Arbitration only in IDLE; no preemption once ISSUE entered.
//    Single req: granted. Both req: PRIO_IFETCH=1 -> I; else the one != last_grant.
//  - Requester must drop req in the cycle after ready_o; IDLE re-grants a req
//    still high (treated as new transaction).
//  - Req dropped by requester mid-transaction: transaction still completes,
//    ready_o still pulses (no abort).
//  - rst_i mid-transaction: next cycle IDLE, no ready_o, slave_req_o=0, and
//    captured rdata cleared; pending transaction is lost.
//  - RD_LATENCY outside 1..4: elaboration error.
// TESTING
//  1 Reset: hold rst_i 3 cycles -> all outputs 0, busy_o=0; release, no req
//    -> slave_req_o stays 0 for 20 cycles.
//  2 D read, L=1: d_req_i=1 addr=0xCD00_0100, slave returns 0xDEADBEEF ->
//    slave_req_o cycle 1 addr 0xCD00_0100 we=0; d_ready_o cycle 3, rdata=0xDEADBEEF.
//  3 D write: addr=0xCD00_0380 be=4'b0011 wdata=0x1234_5678 -> one slave_req_o
//    we=1 be=0011 wdata=0x1234_5678; d_ready_o once, i_ready_o never.
//  4 Conflict RR: d_req_i,i_req_i high same cycle after reset, both held ->
//    order I,D,I,D; each ready_o a single pulse; 4 slave_req_o total.
//  5 PRIO_IFETCH=1, L=3: both held for 3 transactions -> I served every time,
//    ready_o at cycle 5 after req; D starves until i_req_i drops.
//  6 Reset mid-op: assert rst_i during WAIT -> next cycle IDLE, no ready_o
//    pulse ever for that transaction, busy_o=0.

Source files
------------

// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_port_arbiter
// Description : Shares the single Debug Module slave port between a core data
//               requester (D, read/write) and a debug-ROM instruction fetch
//               requester (I, read-only). Each transaction is sequenced as
//               IDLE -> ISSUE -> WAIT -> DONE, with every output registered.
//               Conflicts are resolved round-robin, or always in favour of I
//               when PRIO_IFETCH is set.
// Ports       : clk_i / rst_i          clock, synchronous active-high reset
//               d_req_i .. d_rdata_o   D requester (req/we/addr/be/wdata,
//                                      ready pulse + read data)
//               i_req_i .. i_rdata_o   I requester (req/addr, ready pulse +
//                                      fetched word)
//               slave_*                one-cycle request to the DM slave,
//                                      read data returned RD_LATENCY later
//               busy_o                 high whenever a transaction is active
// Revision    : 1.0 - initial release
// ============================================================================
module dm_port_arbiter #(
  parameter int XLEN        = 32,
  parameter int RD_LATENCY  = 1,
  parameter bit PRIO_IFETCH = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // D requester
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [XLEN-1:0]   d_addr_i,
  input  logic [XLEN/8-1:0] d_be_i,
  input  logic [XLEN-1:0]   d_wdata_i,
  output logic              d_ready_o,
  output logic [XLEN-1:0]   d_rdata_o,
  // I requester
  input  logic              i_req_i,
  input  logic [XLEN-1:0]   i_addr_i,
  output logic              i_ready_o,
  output logic [XLEN-1:0]   i_rdata_o,
  // DM slave port
  output logic              slave_req_o,
  output logic              slave_we_o,
  output logic [XLEN-1:0]   slave_addr_o,
  output logic [XLEN/8-1:0] slave_be_o,
  output logic [XLEN-1:0]   slave_wdata_o,
  input  logic [XLEN-1:0]   slave_rdata_i,
  // status
  output logic              busy_o
);

  localparam int         c_BE_W     = XLEN / 8;
  localparam logic [1:0] c_CNT_INIT = 2'(RD_LATENCY - 1);

  generate
    if ((RD_LATENCY < 1) || (RD_LATENCY > 4)) begin : g_bad_rd_latency
      $error("dm_port_arbiter: RD_LATENCY must be within 1..4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state,       w_state_nxt;
  logic                r_owner_i,     w_owner_i_nxt;   // 1: current owner is I
  logic                r_last_i,      w_last_i_nxt;    // 1: last grant went to I
  logic [1:0]          r_cnt,         w_cnt_nxt;
  logic                r_slave_req,   w_slave_req_nxt;
  logic                r_slave_we,    w_slave_we_nxt;
  logic [XLEN-1:0]     r_slave_addr,  w_slave_addr_nxt;
  logic [c_BE_W-1:0]   r_slave_be,    w_slave_be_nxt;
  logic [XLEN-1:0]     r_slave_wdata, w_slave_wdata_nxt;
  logic                r_d_ready,     w_d_ready_nxt;
  logic                r_i_ready,     w_i_ready_nxt;
  logic [XLEN-1:0]     r_d_rdata,     w_d_rdata_nxt;
  logic [XLEN-1:0]     r_i_rdata,     w_i_rdata_nxt;
  logic                r_busy,        w_busy_nxt;
  logic                w_grant_i;

  // I wins if it is alone, if it has fixed priority, or if D was served last.
  assign w_grant_i = i_req_i && (!d_req_i || PRIO_IFETCH || !r_last_i);

  // Next-state and next-output logic. The slave request fields are latched
  // straight into their output registers on the IDLE->ISSUE edge and fall back
  // to zero on the following edge, so they are only non-zero during ISSUE.
  always_comb begin
    w_state_nxt       = r_state;
    w_owner_i_nxt     = r_owner_i;
    w_last_i_nxt      = r_last_i;
    w_cnt_nxt         = r_cnt;
    w_slave_req_nxt   = 1'b0;
    w_slave_we_nxt    = 1'b0;
    w_slave_addr_nxt  = '0;
    w_slave_be_nxt    = '0;
    w_slave_wdata_nxt = '0;
    w_d_ready_nxt     = 1'b0;
    w_i_ready_nxt     = 1'b0;
    w_d_rdata_nxt     = r_d_rdata;
    w_i_rdata_nxt     = r_i_rdata;

    case (r_state)
      S_IDLE: begin
        if (d_req_i || i_req_i) begin
          w_state_nxt     = S_ISSUE;
          w_owner_i_nxt   = w_grant_i;
          w_slave_req_nxt = 1'b1;
          if (w_grant_i) begin
            // Instruction fetch: always a full-word read.
            w_slave_addr_nxt = i_addr_i;
            w_slave_be_nxt   = '1;
          end else begin
            w_slave_we_nxt    = d_we_i;
            w_slave_addr_nxt  = d_addr_i;
            w_slave_be_nxt    = d_be_i;
            w_slave_wdata_nxt = d_wdata_i;
          end
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = c_CNT_INIT;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 2'd0) begin
          // Slave data is valid in this cycle; capture it for the owner and
          // raise its ready so that both appear together in DONE.
          w_state_nxt = S_DONE;
          if (r_owner_i) begin
            w_i_rdata_nxt = slave_rdata_i;
            w_i_ready_nxt = 1'b1;
          end else begin
            w_d_rdata_nxt = slave_rdata_i;
            w_d_ready_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      S_DONE: begin
        w_last_i_nxt = r_owner_i;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_owner_i     <= 1'b0;
      r_last_i      <= 1'b0;
      r_cnt         <= 2'd0;
      r_slave_req   <= 1'b0;
      r_slave_we    <= 1'b0;
      r_slave_addr  <= '0;
      r_slave_be    <= '0;
      r_slave_wdata <= '0;
      r_d_ready     <= 1'b0;
      r_i_ready     <= 1'b0;
      r_d_rdata     <= '0;
      r_i_rdata     <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_owner_i     <= w_owner_i_nxt;
      r_last_i      <= w_last_i_nxt;
      r_cnt         <= w_cnt_nxt;
      r_slave_req   <= w_slave_req_nxt;
      r_slave_we    <= w_slave_we_nxt;
      r_slave_addr  <= w_slave_addr_nxt;
      r_slave_be    <= w_slave_be_nxt;
      r_slave_wdata <= w_slave_wdata_nxt;
      r_d_ready     <= w_d_ready_nxt;
      r_i_ready     <= w_i_ready_nxt;
      r_d_rdata     <= w_d_rdata_nxt;
      r_i_rdata     <= w_i_rdata_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign d_ready_o     = r_d_ready;
  assign d_rdata_o     = r_d_rdata;
  assign i_ready_o     = r_i_ready;
  assign i_rdata_o     = r_i_rdata;
  assign slave_req_o   = r_slave_req;
  assign slave_we_o    = r_slave_we;
  assign slave_addr_o  = r_slave_addr;
  assign slave_be_o    = r_slave_be;
  assign slave_wdata_o = r_slave_wdata;
  assign busy_o        = r_busy;

endmodule
`default_nettype wire
